// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester valid/ready/data bus plus UART TX data/valid/busy and status; master=sources+TX side, slave=arbiter
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic [DATA_WIDTH-1:0]         TX_P_DATA;
  logic                          TX_DATA_VALID;
  logic                          TX_BUSY;
  logic [NUM_REQ-1:0]            GRANT;
  logic                          CTRL_BUSY;
  logic                          TIMEOUT_ERR;
  modport master (
    output REQ_VALID, REQ_DATA, TX_BUSY,
    input  REQ_READY, TX_P_DATA, TX_DATA_VALID, GRANT, CTRL_BUSY, TIMEOUT_ERR
  );
  modport slave (
    input  REQ_VALID, REQ_DATA, TX_BUSY,
    output REQ_READY, TX_P_DATA, TX_DATA_VALID, GRANT, CTRL_BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX among NUM_REQ byte sources; ports CLK, RST (async high), bus (slave: requests in, TX launch/status out)
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic             CLK,
  input logic             RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  logic [1:0]         state, nxt;
  logic [PW-1:0]      ptr, sel;
  logic [CW-1:0]      cnt;
  logic               found, grant, timeout;
  logic [NUM_REQ-1:0] sel_oh;
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.REQ_VALID[(int'(ptr) + k) % NUM_REQ]) begin
        sel   = PW'((int'(ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign grant   = state == IDLE && found && !bus.TX_BUSY;
  assign sel_oh  = NUM_REQ'(1) << sel;
  assign timeout = cnt == CW'(BUSY_TIMEOUT - 1);
  always_comb
    nxt = state == IDLE      ? (grant ? LAUNCH : IDLE) :
          state == LAUNCH    ? WAIT_BUSY :
          state == WAIT_BUSY ? (bus.TX_BUSY ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY) :
                               (bus.TX_BUSY ? WAIT_DONE : IDLE);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= IDLE;
      ptr               <= '0;
      cnt               <= '0;
      bus.REQ_READY     <= '0;
      bus.GRANT         <= '0;
      bus.TX_P_DATA     <= '0;
      bus.TX_DATA_VALID <= 1'b0;
      bus.CTRL_BUSY     <= 1'b0;
      bus.TIMEOUT_ERR   <= 1'b0;
    end else begin
      state             <= nxt;
      bus.CTRL_BUSY     <= nxt != IDLE;
      bus.REQ_READY     <= grant ? sel_oh : '0;
      bus.TX_DATA_VALID <= state == LAUNCH;
      bus.TIMEOUT_ERR   <= state == WAIT_BUSY && !bus.TX_BUSY && timeout;
      cnt               <= state == WAIT_BUSY ? cnt + 1'b1 : '0;
      if (grant) begin
        bus.TX_P_DATA <= bus.REQ_DATA[sel*DATA_WIDTH +: DATA_WIDTH];
        bus.GRANT     <= sel_oh;
        ptr           <= sel == PW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
      end else if (nxt == IDLE) begin
        bus.GRANT <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with a simple UART TX busy model
module tb_uart_tx_arbiter;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] d [4];
  logic       model_en = 1'b1;
  logic       ext_busy = 1'b0;
  logic [7:0] frame_len = 8'd4;
  logic [7:0] busy_cnt;
  logic [7:0] launches [$];
  logic [3:0] readies [$];
  int         tests = 0;
  int         fails = 0;
  uart_tx_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();
  uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  assign bus.REQ_DATA = {d[3], d[2], d[1], d[0]};
  assign bus.TX_BUSY  = (busy_cnt != 0) | ext_busy;
  always @(posedge CLK or posedge RST)
    if (RST) busy_cnt <= 0;
    else if (model_en && bus.TX_DATA_VALID) busy_cnt <= frame_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  always @(posedge CLK) begin
    if (bus.TX_DATA_VALID) launches.push_back(bus.TX_P_DATA);
    if (bus.REQ_READY != 0) readies.push_back(bus.REQ_READY);
  end
  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.REQ_READY != 0) begin
        g = bus.REQ_READY;
        break;
      end
    end
  endtask
  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.CTRL_BUSY && !bus.TX_BUSY) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_idle: controller never returned to idle", name); end
  endtask
  task automatic test_reset;
    @(negedge CLK);
    tests++; if (bus.GRANT !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", bus.GRANT); end
    tests++; if (bus.CTRL_BUSY !== 1'b0) begin fails++; $display("FAIL reset_ctrl_busy: got %b want 0", bus.CTRL_BUSY); end
    tests++; if (bus.TX_P_DATA !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", bus.TX_P_DATA); end
    tests++; if ({bus.REQ_READY, bus.TX_DATA_VALID, bus.TIMEOUT_ERR} !== 6'b0) begin fails++; $display("FAIL reset_strobes: got %b want 000000", {bus.REQ_READY, bus.TX_DATA_VALID, bus.TIMEOUT_ERR}); end
    RST = 1'b0;
    @(negedge CLK);
  endtask
  task automatic test_single;
    int n = 0;
    int bad = 0;
    frame_len = 8'd100;
    d[0] = 8'h3C;
    bus.REQ_VALID = 4'b0001;
    @(negedge CLK);
    tests++; if (bus.REQ_READY !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b want 0001", bus.REQ_READY); end
    tests++; if (bus.GRANT !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", bus.GRANT); end
    tests++; if (bus.TX_DATA_VALID !== 1'b0) begin fails++; $display("FAIL single_valid_early: got %b want 0", bus.TX_DATA_VALID); end
    bus.REQ_VALID = 4'b0000;
    @(negedge CLK);
    tests++; if (bus.TX_DATA_VALID !== 1'b1) begin fails++; $display("FAIL single_launch: got %b want 1", bus.TX_DATA_VALID); end
    tests++; if (bus.TX_P_DATA !== 8'h3C) begin fails++; $display("FAIL single_data: got %h want 3c", bus.TX_P_DATA); end
    tests++; if (bus.REQ_READY !== 4'b0000) begin fails++; $display("FAIL single_ready_pulse: got %b want 0000", bus.REQ_READY); end
    @(negedge CLK);
    tests++; if (bus.TX_DATA_VALID !== 1'b0) begin fails++; $display("FAIL single_valid_pulse: got %b want 0", bus.TX_DATA_VALID); end
    while (bus.TX_BUSY === 1'b1 && n < 300) begin
      if (bus.GRANT !== 4'b0001 || bus.TX_P_DATA !== 8'h3C) bad++;
      @(negedge CLK);
      n++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL single_hold: %0d cycles lost grant/data, want 0", bad); end
    tests++; if ({bus.GRANT, bus.CTRL_BUSY} !== 5'b00011) begin fails++; $display("FAIL single_busy_fall: got %b want 00011", {bus.GRANT, bus.CTRL_BUSY}); end
    @(negedge CLK);
    tests++; if ({bus.GRANT, bus.CTRL_BUSY} !== 5'b00000) begin fails++; $display("FAIL single_done: got %b want 00000", {bus.GRANT, bus.CTRL_BUSY}); end
    frame_len = 8'd4;
  endtask
  task automatic test_reset_mid_frame;
    logic [3:0] g;
    frame_len = 8'd20;
    d[1] = 8'hA5;
    bus.REQ_VALID = 4'b0010;
    wait_grant(g);
    bus.REQ_VALID = 4'b0000;
    tests++; if (g !== 4'b0010) begin fails++; $display("FAIL rst_mid_grant: got %b want 0010", g); end
    repeat (4) @(negedge CLK);
    tests++; if ({bus.CTRL_BUSY, bus.TX_P_DATA} !== 9'h1A5) begin fails++; $display("FAIL rst_mid_frame: got %h want 1a5", {bus.CTRL_BUSY, bus.TX_P_DATA}); end
    RST = 1'b1;
    #1;
    tests++; if (bus.GRANT !== 4'b0000) begin fails++; $display("FAIL rst_mid_grant_clr: got %b want 0000", bus.GRANT); end
    tests++; if (bus.CTRL_BUSY !== 1'b0) begin fails++; $display("FAIL rst_mid_ctrl_busy: got %b want 0", bus.CTRL_BUSY); end
    tests++; if (bus.TX_P_DATA !== 8'h00) begin fails++; $display("FAIL rst_mid_data: got %h want 00", bus.TX_P_DATA); end
    @(negedge CLK);
    RST = 1'b0;
    frame_len = 8'd4;
    d[0] = 8'h5A;
    bus.REQ_VALID = 4'b0111;
    wait_grant(g);
    bus.REQ_VALID = 4'b0000;
    tests++; if (g !== 4'b0001) begin fails++; $display("FAIL rst_mid_first: got %b want 0001", g); end
    @(negedge CLK);
    tests++; if ({bus.TX_DATA_VALID, bus.TX_P_DATA} !== 9'h15A) begin fails++; $display("FAIL rst_mid_relaunch: got %h want 15a", {bus.TX_DATA_VALID, bus.TX_P_DATA}); end
    wait_idle("rst_mid");
  endtask
  task automatic test_round_robin;
    int n = 0;
    logic [7:0] exp_d;
    logic [3:0] exp_r;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    launches.delete();
    readies.delete();
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    bus.REQ_VALID = 4'b1111;
    while (launches.size() < 5 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    bus.REQ_VALID = 4'b0000;
    tests++; if (launches.size() != 5) begin fails++; $display("FAIL rr_count: got %0d launches want 5", launches.size()); end
    tests++; if (readies.size() != 5) begin fails++; $display("FAIL rr_ready_count: got %0d want 5", readies.size()); end
    for (int i = 0; i < 5 && i < launches.size() && i < readies.size(); i++) begin
      exp_d = 8'h10 + 8'(i % 4);
      exp_r = 4'b0001 << (i % 4);
      tests++; if (launches[i] !== exp_d) begin fails++; $display("FAIL rr_order[%0d]: got %h want %h", i, launches[i], exp_d); end
      tests++; if (readies[i] !== exp_r) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", i, readies[i], exp_r); end
    end
    wait_idle("rr");
  endtask
  task automatic test_wrap_skip;
    logic [3:0] g;
    bus.REQ_VALID = 4'b0100;
    wait_grant(g);
    bus.REQ_VALID = 4'b0000;
    tests++; if (g !== 4'b0100) begin fails++; $display("FAIL wrap_pre: got %b want 0100", g); end
    wait_idle("wrap_pre");
    bus.REQ_VALID = 4'b0101;
    wait_grant(g);
    bus.REQ_VALID = 4'b0100;
    tests++; if (g !== 4'b0001) begin fails++; $display("FAIL wrap_first: got %b want 0001", g); end
    wait_grant(g);
    bus.REQ_VALID = 4'b0000;
    tests++; if (g !== 4'b0100) begin fails++; $display("FAIL wrap_second: got %b want 0100", g); end
    wait_idle("wrap");
  endtask
  task automatic test_timeout;
    logic [3:0] g;
    int early = 0;
    model_en = 1'b0;
    d[3] = 8'h77;
    bus.REQ_VALID = 4'b1000;
    wait_grant(g);
    bus.REQ_VALID = 4'b0001;
    tests++; if (g !== 4'b1000) begin fails++; $display("FAIL to_grant: got %b want 1000", g); end
    @(negedge CLK);
    tests++; if ({bus.TX_DATA_VALID, bus.TX_P_DATA} !== 9'h177) begin fails++; $display("FAIL to_launch: got %h want 177", {bus.TX_DATA_VALID, bus.TX_P_DATA}); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k < 16 && bus.TIMEOUT_ERR !== 1'b0) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL to_early: %0d early pulses want 0", early); end
    tests++; if (bus.TIMEOUT_ERR !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", bus.TIMEOUT_ERR); end
    tests++; if ({bus.GRANT, bus.CTRL_BUSY} !== 5'b00000) begin fails++; $display("FAIL to_release: got %b want 00000", {bus.GRANT, bus.CTRL_BUSY}); end
    @(negedge CLK);
    model_en = 1'b1;
    tests++; if (bus.TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL to_pulse_width: got %b want 0", bus.TIMEOUT_ERR); end
    tests++; if (bus.REQ_READY !== 4'b0001) begin fails++; $display("FAIL to_next: got %b want 0001", bus.REQ_READY); end
    bus.REQ_VALID = 4'b0000;
    wait_idle("to");
  endtask
  task automatic test_ext_busy;
    int bad = 0;
    ext_busy = 1'b1;
    bus.REQ_VALID = 4'b0010;
    repeat (5) begin
      @(negedge CLK);
      if (bus.REQ_READY !== 4'b0000 || bus.GRANT !== 4'b0000 || bus.CTRL_BUSY !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL ext_hold: %0d cycles granted while busy want 0", bad); end
    ext_busy = 1'b0;
    @(negedge CLK);
    bus.REQ_VALID = 4'b0000;
    tests++; if (bus.REQ_READY !== 4'b0010) begin fails++; $display("FAIL ext_ready: got %b want 0010", bus.REQ_READY); end
    tests++; if (bus.GRANT !== 4'b0010) begin fails++; $display("FAIL ext_grant: got %b want 0010", bus.GRANT); end
    wait_idle("ext");
  endtask
  initial begin
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    bus.REQ_VALID = 4'b0000;
    test_reset;
    test_single;
    test_reset_mid_frame;
    test_round_robin;
    test_wrap_skip;
    test_timeout;
    test_ext_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ independent byte sources. Requesters use a valid/ready handshake. The arbiter picks one by round-robin, launches the byte into the UART TX with a one-cycle data-valid pulse, then tracks the transmitter busy flag until the frame completes. It sits between on-chip byte producers (register file, command responder, debug path) and the UART TX data/valid/busy interface, in the TX clock domain.

Parameters:
DATA_WIDTH, 8, byte width; must match the UART TX data width.
NUM_REQ, 4, number of requesters (2..8).
BUSY_TIMEOUT, 16, cycles to wait for TX busy to rise after launch before declaring a fault (>=2).

Ports:
CLK  input  1  TX clock, rising-edge.
RST  input  1  asynchronous reset, active-high.
REQ_VALID  input  NUM_REQ  bit i: requester i holds a byte.
REQ_DATA  input  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH].
REQ_READY  output  NUM_REQ  one-cycle accept strobe; byte i is consumed when REQ_VALID[i] & REQ_READY[i].
TX_P_DATA  output  DATA_WIDTH  byte to UART TX.
TX_DATA_VALID  output  1  one-cycle launch pulse to UART TX.
TX_BUSY  input  1  UART TX busy (high while a frame is on the line).
GRANT  output  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
CTRL_BUSY  output  1  high in any state other than IDLE.
TIMEOUT_ERR  output  1  one-cycle pulse when TX_BUSY fails to rise within BUSY_TIMEOUT.

Behaviour:
- Reset (async, RST=1): state=IDLE, all outputs 0, TX_P_DATA=0, rr pointer=0, timeout counter=0. Takes effect mid-frame; the in-flight byte is abandoned and never re-offered.
- All outputs are registered; none are combinational from inputs.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If REQ_VALID!=0 and TX_BUSY=0, select the first set bit searching from index ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
  - Same edge: latch REQ_DATA slice into TX_P_DATA; set REQ_READY[sel]=1 for exactly one cycle; set GRANT=onehot(sel); ptr<=(sel+1) mod NUM_REQ; go to LAUNCH.
  - If TX_BUSY=1 (foreign/stale frame), stay in IDLE and grant nothing.
- LAUNCH: TX_DATA_VALID=1 for this single cycle; counter cleared; go to WAIT_BUSY. Latency from REQ_VALID sampled in IDLE to TX_DATA_VALID high is 2 cycles.
- WAIT_BUSY:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise increment counter. When counter reaches BUSY_TIMEOUT-1 with TX_BUSY still 0: pulse TIMEOUT_ERR, clear GRANT, go to IDLE. The byte is dropped.
- WAIT_DONE: hold GRANT and TX_P_DATA stable. On TX_BUSY=0 -> IDLE, GRANT cleared. The next grant can occur on the following cycle.
- TX_P_DATA holds its value from latch until the next grant; it does not change during a frame.
- REQ_VALID changes outside IDLE are ignored. A requester deasserting valid while not granted loses nothing.
- Requesters that are not granted must see REQ_READY=0 throughout.
- Single requester continuously valid: one byte per frame with no starvation. All valid: strict rotation 0,1,2,3,0...
- ptr advances only on a grant; a timeout still counts as that requester's turn.

Test Plan:
- Reset mid-frame: grant req1 with 0xA5, assert RST during WAIT_DONE -> all outputs 0 asynchronously; after release, req0 (valid) is granted first.
- Single request: REQ_VALID=0001, data 0x3C; TX model raises busy 1 cycle after valid for 100 cycles -> REQ_READY[0] one cycle, TX_DATA_VALID 2 cycles after request, TX_P_DATA=0x3C, GRANT=0001 until busy falls, CTRL_BUSY=0 one cycle later.
- Round-robin fairness: REQ_VALID=1111 held, bytes 0x10/0x11/0x12/0x13 -> launch order 0x10,0x11,0x12,0x13,0x10; exactly one REQ_READY per frame.
- Pointer wrap/skip: ptr=3 after granting req2, REQ_VALID=0101 -> req0 granted next, then req2.
- Timeout: TX model never raises busy, BUSY_TIMEOUT=16 -> TIMEOUT_ERR pulses 16 cycles after LAUNCH, FSM returns to IDLE, next requester is granted.
- Busy held externally: TX_BUSY=1 while REQ_VALID=0010 -> no grant and no REQ_READY until busy drops, then grant on the next cycle.
